// File: rtl/main_fsm.sv
// rtl/main_fsm.sv - multicycle RV32I control state machine (lw, sw, R, I, jal, beq)
module main_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [3:0] state
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   // Codes 11..15 are never entered; the decoders treat them as all-zero outputs and return to Fetch.
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   state_t state_q;
   state_t state_d;

   // Per-state Moore values before the reset override is applied.
   logic       pc_update;
   logic       branch;
   logic       adr_src_s;
   logic       mem_write_s;
   logic       ir_write_s;
   logic       reg_write_s;
   logic [1:0] result_src_s;
   logic [1:0] alu_src_a_s;
   logic [1:0] alu_src_b_s;
   logic [1:0] alu_op_s;

   // State register: reset returns to Fetch from any state, even mid-instruction.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; op is only consulted in Decode and MemAdr.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_JAL:       state_d = S_JAL;
               OP_BEQ:       state_d = S_BEQ;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (op == OP_LW) begin
               state_d = S_MEMREAD;
            end else if (op == OP_SW) begin
               state_d = S_MEMWRITE;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_MEMREAD:  state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: state_d = S_FETCH;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
         S_BEQ:      state_d = S_FETCH;
         default:    state_d = S_FETCH;
      endcase
   end

   // Moore output decode: everything not named for a state stays 0.
   always_comb begin
      pc_update    = 1'b0;
      branch       = 1'b0;
      adr_src_s    = 1'b0;
      mem_write_s  = 1'b0;
      ir_write_s   = 1'b0;
      reg_write_s  = 1'b0;
      result_src_s = 2'b00;
      alu_src_a_s  = 2'b00;
      alu_src_b_s  = 2'b00;
      alu_op_s     = 2'b00;
      case (state_q)
         S_FETCH: begin
            ir_write_s   = 1'b1;
            alu_src_b_s  = 2'b10;
            result_src_s = 2'b10;
            pc_update    = 1'b1;
         end
         S_DECODE: begin
            alu_src_a_s = 2'b01;
            alu_src_b_s = 2'b01;
         end
         S_MEMADR: begin
            alu_src_a_s = 2'b10;
            alu_src_b_s = 2'b01;
         end
         S_MEMREAD: begin
            adr_src_s = 1'b1;
         end
         S_MEMWB: begin
            result_src_s = 2'b01;
            reg_write_s  = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src_s   = 1'b1;
            mem_write_s = 1'b1;
         end
         S_EXECR: begin
            alu_src_a_s = 2'b10;
            alu_op_s    = 2'b10;
         end
         S_EXECI: begin
            alu_src_a_s = 2'b10;
            alu_src_b_s = 2'b01;
            alu_op_s    = 2'b10;
         end
         S_ALUWB: begin
            reg_write_s = 1'b1;
         end
         S_JAL: begin
            alu_src_a_s = 2'b01;
            alu_src_b_s = 2'b10;
            pc_update   = 1'b1;
         end
         S_BEQ: begin
            alu_src_a_s = 2'b10;
            alu_op_s    = 2'b01;
            branch      = 1'b1;
         end
         default: begin
            pc_update = 1'b0;
         end
      endcase
   end

   // Reset override: show Fetch selects but keep every write enable off; PCWrite follows Zero live.
   always_comb begin
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = 2'b10;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b10;
      ALUOp     = 2'b00;
      if (!reset) begin
         PCWrite   = pc_update | (branch & Zero);
         AdrSrc    = adr_src_s;
         MemWrite  = mem_write_s;
         IRWrite   = ir_write_s;
         RegWrite  = reg_write_s;
         ResultSrc = result_src_s;
         ALUSrcA   = alu_src_a_s;
         ALUSrcB   = alu_src_b_s;
         ALUOp     = alu_op_s;
      end
   end

   assign state = state_q;

endmodule

// File: doc/main_fsm.md
# main_fsm

Multicycle RISC-V control state machine for the RV32I subset lw, sw, R-type, I-type ALU, jal and beq. It sits directly upstream of the ALU decoder. It sequences each instruction through fetch, decode, execute, memory and writeback. Each cycle it drives the datapath enables and multiplexer selects, plus the 2-bit ALUOp that the ALU decoder expands into ALUControl. It also combines PCUpdate with Branch & Zero to produce PCWrite.

## Interface
No parameters.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- op  input  7  instruction opcode (Instr[6:0]), read from the instruction register
- Zero  input  1  ALU zero flag
- PCWrite  output  1  PC register enable = PCUpdate | (Branch & Zero)
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  instruction register (and OldPC) enable
- RegWrite  output  1  register file write enable
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = RD1 (A)
- ALUSrcB  output  2  00 = RD2 (WriteData), 01 = ImmExt, 10 = constant 4
- ALUOp  output  2  to ALU decoder: 00 = add, 01 = subtract, 10 = decode funct
- state  output  4  current state code, for debug

## Operation
- Moore machine: every output is a combinational function of the state register only. The one exception is PCWrite, which also uses Zero.
- In every state, any output not listed below is 0.
- Opcodes: lw 0000011, sw 0100011, R 0110011, I 0010011, jal 1101111, beq 1100011.
- States, their codes, outputs and next state:
  - S0 Fetch (0): AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next state is S1.
  - S1 Decode (1): ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by op: lw/sw go to S2, R goes to S6, I goes to S7, jal goes to S9, beq goes to S10. Any other opcode goes to S0 (treated as a nop, no write enables asserted).
  - S2 MemAdr (2): ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw goes to S3, sw goes to S5.
  - S3 MemRead (3): ResultSrc=00, AdrSrc=1. Next state is S4.
  - S4 MemWB (4): ResultSrc=01, RegWrite=1. Next state is S0.
  - S5 MemWrite (5): ResultSrc=00, AdrSrc=1, MemWrite=1. Next state is S0.
  - S6 ExecuteR (6): ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state is S8.
  - S7 ExecuteI (7): ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state is S8.
  - S8 ALUWB (8): ResultSrc=00, RegWrite=1. Next state is S0.
  - S9 JAL (9): ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next state is S8.
  - S10 BEQ (10): ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next state is S0.
- PCUpdate and Branch are internal signals only; they are not ports.
- Codes 11–15 are illegal. In an illegal state all outputs are 0 and the next state is S0.
- op is sampled only in S1 and S2. It must be stable from the IRWrite edge until the instruction returns to S0.

## Timing
- The state register updates on the rising edge of clk.
- reset=1 at an edge loads S0, regardless of the current state. This includes reset arriving mid-instruction, for example in S5: no MemWrite is asserted in the following cycle.
- While reset=1, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0. The selects and ALUOp show S0 values.
- After reset deasserts, the first cycle is Fetch.
- Cycles per instruction, counted from Fetch to the next Fetch exclusive:
  - lw 5
  - sw 4
  - R 4
  - I 4
  - jal 4
  - beq 3
  - unknown opcode 2
- PCWrite is combinational with Zero. In S10 it follows Zero within the same cycle.
- ALUOp is valid in the same cycle as the state, so ALUControl settles within that cycle.

## Test plan
- Reset held for 2 cycles, then released → state=0; IRWrite, PCWrite, RegWrite and MemWrite are all 0 during reset. The first cycle after release has IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10.
- op=0000011 (lw) → state sequence 0,1,2,3,4,0. RegWrite=1 with ResultSrc=01 only in state 4. AdrSrc=1 only in state 3.
- op=0110011 (R) → states 0,1,6,8,0 with ALUOp=10 and ALUSrcB=00 in state 6. op=0010011 (I) → states 0,1,7,8,0 with ALUSrcB=01 in state 7.
- op=1100011 (beq) with Zero=1 → in state 10, ALUOp=01 and PCWrite=1. Same with Zero=0 → PCWrite=0. Both return to state 0 after 3 cycles.
- op=1101111 (jal) → states 0,1,9,8,0. PCWrite=1 in state 9, RegWrite=1 in state 8. op=0100011 (sw) → states 0,1,2,5,0 with MemWrite=1 only in state 5.
- op=1111111 → states 0,1,0 with no write enable ever asserted. Reset asserted while in state 5 → next state 0 and MemWrite=0.
